core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
Multi-cycle control sequencer for the ID / Reg_File / EXE datapath. It owns the program counter and instruction register, and fetches from instruction memory over a req/ack handshake. It steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK. Register-file writes are gated so that each instruction commits exactly once, in its WRITEBACK cycle.

Parameters:
- PC_WIDTH, 32, width of PC, imem_addr and branch_target.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per non-branch instruction.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse; begins execution from IDLE.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  PC_WIDTH  fetch address; always equals pc.
- imem_ack  input  1  fetch data valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  instruction register; drives ID.instruction.
- id_write_enable  input  1  write-enable decoded by ID.
- rf_write_enable  output  1  gated write-enable to Reg_File.
- halt  input  1  decoded halt indication from ID.
- branch_taken  input  1  redirect PC at WRITEBACK.
- branch_target  input  PC_WIDTH  redirect address.
- pc  output  PC_WIDTH  current program counter.
- state  output  3  encoded FSM state.
- busy  output  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.
- retired  output  32  count of completed instructions.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, instr=0, imem_req=0, rf_write_enable=0, busy=0, retired=0.
- Reset takes priority over all other inputs in every state, including mid-fetch. Any outstanding fetch is abandoned, and a late imem_ack is ignored.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5. Codes 6 and 7 go to IDLE on the next cycle.
- IDLE: wait for start=1, then go to FETCH. Other inputs are ignored.
- FETCH:
  - imem_req=1 combinationally while in FETCH.
  - Remain in FETCH until imem_ack=1.
  - On ack: instr <= imem_rdata, then go to DECODE.
  - Ack in the first FETCH cycle is legal (zero wait states).
- DECODE: one cycle; ID outputs settle from instr.
  - halt=1 goes to HALTED with pc unchanged and retired not incremented.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle for EXE to settle, then go to WRITEBACK.
- WRITEBACK: one cycle.
  - rf_write_enable = id_write_enable in this cycle only; it is 0 in all other states.
  - pc <= branch_taken ? branch_target : pc + PC_STEP, modulo 2^PC_WIDTH (wraps silently).
  - retired <= retired + 1 (wraps at 2^32).
  - Then go to FETCH.
- HALTED: imem_req=0, busy=0; only rst exits. start is ignored.
- imem_ack outside FETCH is ignored.
- start while busy or HALTED is ignored.
- halt and branch_taken are sampled only in DECODE and WRITEBACK respectively.
- instr holds its value from the FETCH ack until the next ack.
- Minimum latency is 4 cycles per instruction; each fetch wait cycle adds 1.

Test Plan:
- Reset/idle: assert rst 2 cycles, hold start=0 for 5 cycles -> state=0, pc=0, imem_req=0, rf_write_enable=0, retired=0 throughout.
- Zero-wait run: start pulse; imem_ack=1 whenever imem_req is high, rdata=0x0000_FFFF then 0x0200_EEEE; id_write_enable=1 -> instr updates in the cycle after each ack; rf_write_enable high exactly 1 cycle per instruction, 4 cycles apart; pc 0 -> 4 -> 8; retired=2.
- Wait states: delay imem_ack by 3 cycles -> imem_req held 4 cycles with imem_addr stable; instr unchanged until ack; that instruction takes 7 cycles in total.
- Branch: at WRITEBACK drive branch_taken=1, branch_target=0x100 -> next imem_addr=0x100. branch_taken=1 during EXECUTE only -> pc advances by 4.
- Halt: drive halt=1 during DECODE of the 3rd instruction -> state=5, busy=0, rf_write_enable never asserts for it, retired=2, pc=8; a subsequent start pulse has no effect.
- Reset mid-operation and wrap: rst asserted in FETCH with ack pending -> IDLE, pc=RESET_PC, the late ack is ignored. Force pc=0xFFFF_FFFC and run a non-branch instruction -> pc=0.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control for the
// ID / Reg_File / EXE datapath. Owns pc, the instruction register and the
// retired-instruction counter; fetches over a simple req/ack handshake.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | wait for start pulse
//  FETCH     | imem_req high until imem_ack; capture imem_rdata into instr
//  DECODE    | ID settles from instr; halt here ends the program
//  EXECUTE   | EXE settles
//  WRITEBACK | single register-file commit, pc update, retired count
//  HALTED    | parked; only reset leaves
module core_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned         PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    input  logic                id_write_enable,
    output logic                rf_write_enable,
    input  logic                halt,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [2:0]          state,
    output logic                busy,
    output logic [31:0]         retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    state_t state_q;
    state_t state_nxt;

    localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(PC_STEP);

    assign state     = state_q;
    assign imem_addr = pc;

    // State register plus the datapath registers it controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc      <= RESET_PC;
            instr   <= '0;
            retired <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_q == S_FETCH && imem_ack) begin
                instr <= imem_rdata;
            end
            if (state_q == S_WRITEBACK) begin
                pc      <= branch_taken ? branch_target : pc + PC_INC;
                retired <= retired + 32'd1;
            end
        end
    end

    // Next-state decode and per-state outputs; unused codes recover to IDLE.
    always_comb begin
        state_nxt       = state_q;
        imem_req        = 1'b0;
        rf_write_enable = 1'b0;
        busy            = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_ack) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                busy      = 1'b1;
                state_nxt = halt ? S_HALTED : S_EXECUTE;
            end
            S_EXECUTE: begin
                busy      = 1'b1;
                state_nxt = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                busy            = 1'b1;
                rf_write_enable = id_write_enable;
                state_nxt       = S_FETCH;
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: reset, zero-wait and wait-state fetches,
// branch redirect, pc wrap, halt and reset during a pending fetch.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        id_write_enable;
    logic        rf_write_enable;
    logic        halt;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        busy;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    core_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .id_write_enable(id_write_enable),
        .rf_write_enable(rf_write_enable),
        .halt           (halt),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .pc             (pc),
        .state          (state),
        .busy           (busy),
        .retired        (retired)
    );

    always #5 clk = ~clk;

    // Advance one cycle; observation window is 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction starting in a FETCH window; ends in the next window.
    task automatic run_instr(input int waits, input logic [31:0] word,
                             input logic br, input logic [31:0] tgt);
        imem_ack = 1'b0;
        repeat (waits) tick();
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();              // DECODE
        imem_ack = 1'b0;
        tick();              // EXECUTE
        tick();              // WRITEBACK
        branch_taken  = br;
        branch_target = tgt;
        tick();              // FETCH / next
        branch_taken  = 1'b0;
        branch_target = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        tick();
        tick();
        total++; if (state !== 3'd0)   begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (pc !== 32'h0)     begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
        total++; if (instr !== 32'h0)  begin bad++; $display("FAIL reset_instr got=%h exp=0", instr); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (state !== 3'd0 || pc !== 32'h0 || imem_req !== 1'b0 ||
                rf_write_enable !== 1'b0 || retired !== 32'h0) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d got state=%0d pc=%h req=%b rfwe=%b ret=%0d exp 0/0/0/0/0",
                         i, state, pc, imem_req, rf_write_enable, retired);
            end
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] words [2];
        logic [2:0]  exp_state [8];
        int n_ack;
        int rf_cnt;
        words[0] = 32'h0000_FFFF;
        words[1] = 32'h0200_EEEE;
        exp_state = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4};
        n_ack  = 0;
        rf_cnt = 0;
        id_write_enable = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            total++;
            if (state !== exp_state[c]) begin
                bad++; $display("FAIL zw_state cyc=%0d got=%0d exp=%0d", c, state, exp_state[c]);
            end
            total++;
            if (rf_write_enable !== (c == 3 || c == 7)) begin
                bad++; $display("FAIL zw_rfwe cyc=%0d got=%b exp=%b", c, rf_write_enable, (c == 3 || c == 7));
            end
            if (c == 1 || c == 5) begin
                total++;
                if (instr !== words[(c == 1) ? 0 : 1]) begin
                    bad++; $display("FAIL zw_instr cyc=%0d got=%h exp=%h", c, instr, words[(c == 1) ? 0 : 1]);
                end
            end
            if (c == 4) begin
                total++;
                if (imem_addr !== 32'h4) begin bad++; $display("FAIL zw_addr1 got=%h exp=4", imem_addr); end
            end
            if (rf_write_enable === 1'b1) rf_cnt++;
            imem_ack = imem_req;
            if (imem_req === 1'b1) begin
                imem_rdata = words[n_ack];
                n_ack++;
            end
            tick();
        end
        imem_ack = 1'b0;
        total++; if (rf_cnt != 2)       begin bad++; $display("FAIL zw_rfwe_count got=%0d exp=2", rf_cnt); end
        total++; if (pc !== 32'h8)      begin bad++; $display("FAIL zw_pc got=%h exp=8", pc); end
        total++; if (retired !== 32'd2) begin bad++; $display("FAIL zw_retired got=%0d exp=2", retired); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL zw_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_wait_states();
        int cycles;
        int req_cycles;
        cycles = 0;
        req_cycles = 0;
        imem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr !== 32'h0200_EEEE || state !== 3'd1) begin
                bad++;
                $display("FAIL ws_hold cyc=%0d got req=%b addr=%h instr=%h state=%0d exp 1/8/0200eeee/1",
                         c, imem_req, imem_addr, instr, state);
            end
            if (imem_req === 1'b1) req_cycles++;
            tick();
            cycles++;
        end
        if (imem_req === 1'b1) req_cycles++;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        cycles++;
        imem_ack = 1'b0;
        total++; if (instr !== 32'h1234_5678) begin bad++; $display("FAIL ws_instr got=%h exp=12345678", instr); end
        while (state !== 3'd1 && cycles < 20) begin
            tick();
            cycles++;
        end
        total++; if (req_cycles != 4) begin bad++; $display("FAIL ws_req_cycles got=%0d exp=4", req_cycles); end
        total++; if (cycles != 7)     begin bad++; $display("FAIL ws_latency got=%0d exp=7", cycles); end
        total++; if (pc !== 32'hC)    begin bad++; $display("FAIL ws_pc got=%h exp=c", pc); end
        total++; if (retired !== 32'd3) begin bad++; $display("FAIL ws_retired got=%0d exp=3", retired); end
    endtask

    task automatic test_branch();
        run_instr(0, 32'hAAAA_0001, 1'b1, 32'h0000_0100);
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL br_taken_addr got=%h exp=100", imem_addr); end
        total++; if (state !== 3'd1)        begin bad++; $display("FAIL br_state got=%0d exp=1", state); end
        // branch_taken only during EXECUTE must not redirect
        imem_ack   = 1'b1;
        imem_rdata = 32'hAAAA_0002;
        tick();
        imem_ack = 1'b0;
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0300;
        tick();
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        tick();
        total++; if (pc !== 32'h104)    begin bad++; $display("FAIL br_exec_only_pc got=%h exp=104", pc); end
        total++; if (retired !== 32'd5) begin bad++; $display("FAIL br_retired got=%0d exp=5", retired); end
    endtask

    task automatic test_wrap();
        run_instr(0, 32'hBBBB_0001, 1'b1, 32'hFFFF_FFFC);
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre got=%h exp=fffffffc", pc); end
        run_instr(1, 32'hBBBB_0002, 1'b0, 32'h0);
        total++; if (pc !== 32'h0)      begin bad++; $display("FAIL wrap_pc got=%h exp=0", pc); end
        total++; if (retired !== 32'd7) begin bad++; $display("FAIL wrap_retired got=%0d exp=7", retired); end
    endtask

    task automatic test_halt();
        int rf_seen;
        rf_seen = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_instr(0, 32'hCCCC_0001, 1'b0, 32'h0);
        run_instr(2, 32'hCCCC_0002, 1'b0, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hCCCC_0003;
        tick();
        imem_ack = 1'b0;
        total++; if (state !== 3'd2) begin bad++; $display("FAIL halt_decode got=%0d exp=2", state); end
        if (rf_write_enable === 1'b1) rf_seen++;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        total++; if (state !== 3'd5)    begin bad++; $display("FAIL halt_state got=%0d exp=5", state); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL halt_busy got=%b exp=0", busy); end
        total++; if (pc !== 32'h8)      begin bad++; $display("FAIL halt_pc got=%h exp=8", pc); end
        total++; if (retired !== 32'd2) begin bad++; $display("FAIL halt_retired got=%0d exp=2", retired); end
        for (int c = 0; c < 4; c++) begin
            start    = (c == 0);
            imem_ack = (c == 2);
            if (rf_write_enable === 1'b1) rf_seen++;
            tick();
            total++;
            if (state !== 3'd5 || imem_req !== 1'b0 || pc !== 32'h8) begin
                bad++;
                $display("FAIL halt_sticky cyc=%0d got state=%0d req=%b pc=%h exp 5/0/8", c, state, imem_req, pc);
            end
        end
        start = 1'b0;
        imem_ack = 1'b0;
        total++; if (rf_seen != 0) begin bad++; $display("FAIL halt_rfwe got=%0d exp=0", rf_seen); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_instr(0, 32'hDDDD_0001, 1'b0, 32'h0);
        tick();
        total++; if (state !== 3'd1 || pc !== 32'h4) begin
            bad++; $display("FAIL rm_pre got state=%0d pc=%h exp 1/4", state, pc);
        end
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        total++; if (state !== 3'd0 || pc !== 32'h0 || instr !== 32'h0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL rm_reset got state=%0d pc=%h instr=%h req=%b exp 0/0/0/0", state, pc, instr, imem_req);
        end
        tick();
        imem_ack = 1'b0;
        total++; if (state !== 3'd0 || instr !== 32'h0 || retired !== 32'h0) begin
            bad++; $display("FAIL rm_late_ack got state=%0d instr=%h ret=%0d exp 0/0/0", state, instr, retired);
        end
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;
        id_write_enable = 1'b0;
        halt            = 1'b0;
        branch_taken    = 1'b0;
        branch_target   = 32'h0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
